agc_session_scheduler: RTL and testbench



---
 rtl/agc_session_scheduler.sv | 161 ++++++++++++++++
 tb/tb_agc_session_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_session_scheduler.sv
// Session scheduler for the AGC core: holds the core in reset, runs one
// binary-search per packet, then freezes the resulting gain until the packet ends.
module agc_session_scheduler #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter logic [5:0]  DEFAULT_GAIN   = 6'd32,
    parameter logic [3:0]  LOSS_THRESH    = 4'd2,
    parameter int unsigned LOSS_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       enable,
    input  logic       rx_start,
    input  logic       rx_end,
    input  logic [3:0] amplified_signal,
    input  logic       agc_done,
    input  logic [5:0] agc_gain,
    output logic       agc_resetn,
    output logic [5:0] gain_hold,
    output logic       gain_valid,
    output logic       timeout_flag,
    output logic [1:0] state_out,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEARCH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] LOSS_MAX     = 16'(LOSS_CYCLES);

    state_t      state, state_d;
    logic [15:0] cyc_cnt, cyc_cnt_d;
    logic [15:0] lo_cnt, lo_cnt_d;
    logic        agc_resetn_d;
    logic [5:0]  gain_hold_d;
    logic        gain_valid_d;
    logic        timeout_flag_d;
    logic [7:0]  loss_count_d;

    logic        low_sample;
    logic [15:0] cyc_inc;
    logic [15:0] lo_inc;

    assign low_sample = (amplified_signal < LOSS_THRESH);
    assign cyc_inc    = cyc_cnt + 16'd1;
    assign lo_inc     = (lo_cnt == LOSS_MAX) ? lo_cnt : lo_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state        <= IDLE;
            cyc_cnt      <= 16'd0;
            lo_cnt       <= 16'd0;
            agc_resetn   <= 1'b0;
            gain_hold    <= DEFAULT_GAIN;
            gain_valid   <= 1'b0;
            timeout_flag <= 1'b0;
            loss_count   <= 8'd0;
        end else begin
            state        <= state_d;
            cyc_cnt      <= cyc_cnt_d;
            lo_cnt       <= lo_cnt_d;
            agc_resetn   <= agc_resetn_d;
            gain_hold    <= gain_hold_d;
            gain_valid   <= gain_valid_d;
            timeout_flag <= timeout_flag_d;
            loss_count   <= loss_count_d;
        end
    end

    always_comb begin
        state_d        = state;
        cyc_cnt_d      = cyc_cnt;
        lo_cnt_d       = lo_cnt;
        gain_hold_d    = gain_hold;
        gain_valid_d   = gain_valid;
        timeout_flag_d = timeout_flag;
        loss_count_d   = loss_count;

        if (!enable) begin
            // Disable beats every other event; the last gain stays published.
            state_d      = IDLE;
            gain_valid_d = 1'b0;
            cyc_cnt_d    = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt_d = 16'd0;
                    if (rx_start) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (rx_start) begin
                        cyc_cnt_d = 16'd0;
                    end else if (cyc_cnt == SETTLE_LAST) begin
                        state_d        = SEARCH;
                        cyc_cnt_d      = 16'd0;
                        timeout_flag_d = 1'b0;
                    end else begin
                        cyc_cnt_d = cyc_inc;
                    end
                end
                SEARCH: begin
                    // A new preamble abandons the search without capturing.
                    if (rx_start) begin
                        state_d   = SETTLE;
                        cyc_cnt_d = 16'd0;
                    end else if (agc_done) begin
                        state_d      = HOLD;
                        cyc_cnt_d    = 16'd0;
                        gain_hold_d  = agc_gain;
                        gain_valid_d = 1'b1;
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        state_d        = HOLD;
                        cyc_cnt_d      = 16'd0;
                        gain_hold_d    = DEFAULT_GAIN;
                        gain_valid_d   = 1'b1;
                        timeout_flag_d = 1'b1;
                    end else begin
                        cyc_cnt_d = cyc_inc;
                    end
                end
                HOLD: begin
                    lo_cnt_d = low_sample ? lo_inc : 16'd0;
                    if (rx_start) begin
                        state_d      = SETTLE;
                        cyc_cnt_d    = 16'd0;
                        gain_valid_d = 1'b0;
                    end else if (rx_end) begin
                        state_d      = IDLE;
                        gain_valid_d = 1'b0;
                    end else if (low_sample && lo_inc == LOSS_MAX) begin
                        state_d      = IDLE;
                        gain_valid_d = 1'b0;
                        if (loss_count != 8'hFF) begin
                            loss_count_d = loss_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The low-sample run only means something while holding a gain.
        if (state_d != HOLD) begin
            lo_cnt_d = 16'd0;
        end
        agc_resetn_d = (state_d == SEARCH);
    end

    assign state_out = state;

endmodule

// File: tb/tb_agc_session_scheduler.sv
// Directed bench for agc_session_scheduler: a countdown-style session model is
// compared against the DUT every cycle, plus literal checks at key points.
module tb_agc_session_scheduler;

    localparam int SETTLE   = 16;
    localparam int TIMEOUT  = 24;
    localparam int DEF_GAIN = 32;
    localparam int THRESH   = 2;
    localparam int LOSS     = 64;

    logic       clk;
    logic       RESETn;
    logic       enable;
    logic       rx_start;
    logic       rx_end;
    logic [3:0] amplified_signal;
    logic       agc_done;
    logic [5:0] agc_gain;
    logic       agc_resetn;
    logic [5:0] gain_hold;
    logic       gain_valid;
    logic       timeout_flag;
    logic [1:0] state_out;
    logic [7:0] loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    agc_session_scheduler #(
        .SETTLE_CYCLES (SETTLE),
        .SEARCH_TIMEOUT(TIMEOUT),
        .DEFAULT_GAIN  (6'd32),
        .LOSS_THRESH   (4'd2),
        .LOSS_CYCLES   (LOSS)
    ) u_dut (
        .clk             (clk),
        .RESETn          (RESETn),
        .enable          (enable),
        .rx_start        (rx_start),
        .rx_end          (rx_end),
        .amplified_signal(amplified_signal),
        .agc_done        (agc_done),
        .agc_gain        (agc_gain),
        .agc_resetn      (agc_resetn),
        .gain_hold       (gain_hold),
        .gain_valid      (gain_valid),
        .timeout_flag    (timeout_flag),
        .state_out       (state_out),
        .loss_count      (loss_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- session model ----------------
    // Phase numbers are the published state_out values. Settle and search are
    // tracked as remaining-cycle countdowns, loss as a run length of low samples.
    int m_phase       = 0;
    int m_settle_left = 0;
    int m_search_left = 0;
    int m_low_run     = 0;
    int m_gain        = DEF_GAIN;
    int m_valid       = 0;
    int m_timeout     = 0;
    int m_losses      = 0;
    bit started       = 1'b0;

    task automatic model_step();
        if (!RESETn) begin
            m_phase = 0; m_settle_left = 0; m_search_left = 0; m_low_run = 0;
            m_gain = DEF_GAIN; m_valid = 0; m_timeout = 0; m_losses = 0;
        end else if (!enable) begin
            m_phase = 0;
            m_valid = 0;
        end else begin
            case (m_phase)
                0: if (rx_start) begin
                    m_phase = 1;
                    m_settle_left = SETTLE;
                end
                1: if (rx_start) begin
                    m_settle_left = SETTLE;
                end else begin
                    m_settle_left = m_settle_left - 1;
                    if (m_settle_left == 0) begin
                        m_phase = 2;
                        m_search_left = TIMEOUT;
                        m_timeout = 0;
                    end
                end
                2: if (rx_start) begin
                    m_phase = 1;
                    m_settle_left = SETTLE;
                end else if (agc_done) begin
                    m_phase = 3; m_gain = int'(agc_gain); m_valid = 1; m_low_run = 0;
                end else begin
                    m_search_left = m_search_left - 1;
                    if (m_search_left == 0) begin
                        m_phase = 3; m_gain = DEF_GAIN; m_valid = 1; m_timeout = 1; m_low_run = 0;
                    end
                end
                default: begin
                    if (int'(amplified_signal) < THRESH)
                        m_low_run = (m_low_run >= LOSS) ? LOSS : m_low_run + 1;
                    else
                        m_low_run = 0;
                    if (rx_start) begin
                        m_phase = 1; m_settle_left = SETTLE; m_valid = 0;
                    end else if (rx_end) begin
                        m_phase = 0; m_valid = 0;
                    end else if (m_low_run == LOSS) begin
                        m_phase = 0; m_valid = 0;
                        m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk) begin
        model_step();
        started = 1'b1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model state_out", int'(state_out), m_phase);
            check("model agc_resetn", int'(agc_resetn), (m_phase == 2) ? 1 : 0);
            check("model gain_hold", int'(gain_hold), m_gain);
            check("model gain_valid", int'(gain_valid), m_valid);
            check("model timeout_flag", int'(timeout_flag), m_timeout);
            check("model loss_count", int'(loss_count), m_losses);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        rx_start = 1'b1;
        step(1);
        rx_start = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        RESETn = 1'b0; enable = 1'b0; rx_start = 1'b0; rx_end = 1'b0;
        amplified_signal = 4'd8; agc_done = 1'b0; agc_gain = 6'd0;
        step(3);
        check("reset state", int'(state_out), 0);
        check("reset agc_resetn", int'(agc_resetn), 0);
        check("reset gain_hold", int'(gain_hold), 32);
        check("reset gain_valid", int'(gain_valid), 0);
        check("reset loss_count", int'(loss_count), 0);
        RESETn = 1'b1;
        enable = 1'b1;
        step(5);

        // Normal run: settle for 16 cycles, then done with gain 45.
        pulse_start();
        check("settle first cycle", int'(state_out), 1);
        check("settle core in reset", int'(agc_resetn), 0);
        step(15);
        check("settle last cycle", int'(state_out), 1);
        step(1);
        check("search entered", int'(state_out), 2);
        check("search releases core", int'(agc_resetn), 1);
        step(13);
        agc_done = 1'b1; agc_gain = 6'd45;
        step(1);
        agc_done = 1'b0;
        check("capture gain", int'(gain_hold), 45);
        check("capture valid", int'(gain_valid), 1);
        check("capture state hold", int'(state_out), 3);
        check("hold core in reset", int'(agc_resetn), 0);

        // rx_end alone returns to idle, gain retained.
        rx_end = 1'b1;
        step(1);
        rx_end = 1'b0;
        check("rx_end idle", int'(state_out), 0);
        check("rx_end valid drop", int'(gain_valid), 0);
        check("rx_end gain kept", int'(gain_hold), 45);

        // Timeout: 24 cycles in SEARCH with no done.
        pulse_start();
        step(16);
        check("timeout search start", int'(state_out), 2);
        step(TIMEOUT - 1);
        check("timeout last search cycle", int'(state_out), 2);
        step(1);
        check("timeout state hold", int'(state_out), 3);
        check("timeout default gain", int'(gain_hold), 32);
        check("timeout flag", int'(timeout_flag), 1);
        check("timeout valid", int'(gain_valid), 1);

        // rx_start and rx_end together in HOLD: retrain wins.
        rx_start = 1'b1; rx_end = 1'b1;
        step(1);
        rx_start = 1'b0; rx_end = 1'b0;
        check("retrain state", int'(state_out), 1);
        check("retrain valid drop", int'(gain_valid), 0);

        // Done on the timeout cycle: done wins.
        step(16);
        check("tie search start", int'(timeout_flag), 0);
        step(TIMEOUT - 1);
        agc_done = 1'b1; agc_gain = 6'd17;
        step(1);
        agc_done = 1'b0;
        check("tie gain", int'(gain_hold), 17);
        check("tie timeout flag", int'(timeout_flag), 0);
        check("tie state hold", int'(state_out), 3);

        // Loss of signal: 63 lows, one strong sample, then 64 lows.
        amplified_signal = 4'd1;
        step(63);
        check("loss short run stays", int'(state_out), 3);
        amplified_signal = 4'd5;
        step(1);
        amplified_signal = 4'd1;
        step(63);
        check("loss 63 stays", int'(state_out), 3);
        step(1);
        amplified_signal = 4'd8;
        check("loss exit idle", int'(state_out), 0);
        check("loss count", int'(loss_count), 1);
        check("loss valid drop", int'(gain_valid), 0);
        check("loss gain kept", int'(gain_hold), 17);

        // Enable dropped mid-search.
        pulse_start();
        step(16 + 3);
        check("search before disable", int'(agc_resetn), 1);
        enable = 1'b0;
        step(1);
        check("disable idle", int'(state_out), 0);
        check("disable core reset", int'(agc_resetn), 0);
        enable = 1'b1;
        step(2);

        // rx_start during SEARCH restarts settle with no capture, even with done.
        pulse_start();
        step(16 + 2);
        rx_start = 1'b1; agc_done = 1'b1; agc_gain = 6'd9;
        step(1);
        rx_start = 1'b0; agc_done = 1'b0;
        check("restart state settle", int'(state_out), 1);
        check("restart no capture", int'(gain_hold), 17);
        step(15);
        check("restart settle full length", int'(state_out), 1);
        step(1);
        agc_done = 1'b1; agc_gain = 6'd50;
        step(1);
        agc_done = 1'b0;
        check("restart capture", int'(gain_hold), 50);

        // Reset while holding.
        step(4);
        RESETn = 1'b0;
        step(1);
        check("midreset state", int'(state_out), 0);
        check("midreset gain", int'(gain_hold), 32);
        check("midreset valid", int'(gain_valid), 0);
        check("midreset loss_count", int'(loss_count), 0);
        check("midreset timeout", int'(timeout_flag), 0);
        RESETn = 1'b1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
